mips_store_buffer: RTL and testbench

Posted-write buffer between the MEM pipeline stage and the data memory of the 5-stage MIPS core. Stores retire from MEM into a small FIFO in one cycle and drain to data memory one per cycle whenever the memory port is not serving a load. Loads query the buffer so they never read stale memory. Partially covered loads raise a conflict so the hazard logic stalls MEM until the entry drains.

---
 rtl/mips_store_buffer_pkg.sv | 31 +++
 rtl/mips_store_buffer_if.sv | 46 ++++
 rtl/mips_store_buffer_sb_fwd_merge.sv | 49 ++++
 rtl/mips_store_buffer.sv | 97 +++++++++
 tb/tb_mips_store_buffer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_store_buffer_pkg
// Purpose  : Shared MIPS store-buffer types and constants: buffer depth,
//            byte-enable encodings and the FIFO entry layout.
// Revision : 1.0  initial release
// ============================================================================
package mips_store_buffer_pkg;

    localparam int SB_DEPTH    = 4;
    localparam int SB_AW       = 10;
    // Entries hold a full 32-bit address field so the struct does not depend
    // on the per-instance AW; instances zero-extend and truncate as needed.
    localparam int SB_ADDR_MAX = 32;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;

    typedef struct packed {
        logic [SB_ADDR_MAX-1:0] addr;
        logic [31:0]            data;
        logic [3:0]             be;
    } sb_entry_t;

endpackage : mips_store_buffer_pkg
`default_nettype wire

// File: rtl/mips_store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_store_buffer_if
// Purpose  : Store, load-lookup and data-memory write bundle for the store
//            buffer. master = MEM stage / memory side, slave = buffer.
// Revision : 1.0  initial release
// ============================================================================
interface mips_store_buffer_if
    import mips_store_buffer_pkg::*;
#(
    parameter int AW = SB_AW
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [3:0]    st_be;
    logic          st_ready;

    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [31:0]   ld_data;
    logic          ld_conflict;

    logic          dm_busy;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_data;
    logic [3:0]    dm_be;

    logic          empty;

    modport master (
        output st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, dm_busy,
        input  st_ready, ld_hit, ld_data, ld_conflict,
               dm_we, dm_addr, dm_data, dm_be, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, dm_busy,
        output st_ready, ld_hit, ld_data, ld_conflict,
               dm_we, dm_addr, dm_data, dm_be, empty
    );

endinterface : mips_store_buffer_if
`default_nettype wire

// File: rtl/mips_store_buffer_sb_fwd_merge.sv
`default_nettype none
// ============================================================================
// Module   : sb_fwd_merge
// Purpose  : Combinational load-forwarding merge. Walks the live entries from
//            oldest to newest so later stores overwrite earlier bytes.
// Revision : 1.0  initial release
// ============================================================================
module sb_fwd_merge
    import mips_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW
) (
    input  sb_entry_t                entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic [AW-1:0]            ld_addr,
    output logic [31:0]              data,
    output logic [3:0]               covered,
    output logic                     any_match
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    // Oldest-to-newest byte merge over the occupied slots only.
    always_comb begin
        data      = '0;
        covered   = '0;
        any_match = 1'b0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) &&
                (entries[idx].addr == SB_ADDR_MAX'(ld_addr))) begin
                any_match = 1'b1;
                covered   = covered | entries[idx].be;
                for (int b = 0; b < 4; b++) begin
                    if (entries[idx].be[b]) begin
                        data[8*b +: 8] = entries[idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule : sb_fwd_merge
`default_nettype wire

// File: rtl/mips_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mips_store_buffer
// Purpose  : Posted-write FIFO between MEM and data memory. Accepts one store
//            per cycle, drains one per idle memory cycle, forwards to loads.
// Revision : 1.0  initial release
// ============================================================================
module mips_store_buffer
    import mips_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW
) (
    input  wire                 clk,
    input  wire                 rst,
    mips_store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t     entries [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          is_empty;
    logic          is_full;
    logic          push;
    logic          pop;

    logic [31:0]   fwd_data;
    logic [3:0]    fwd_cov;
    logic          fwd_any;

    assign is_empty = (count == '0);
    assign is_full  = (count == CW'(DEPTH));

    // rst gates the drain so nothing reaches memory in the reset cycle.
    assign pop      = !is_empty && !bus.dm_busy && !rst;
    assign push     = bus.st_valid && bus.st_ready;

    assign bus.st_ready = !is_full || pop;
    assign bus.empty    = is_empty;
    assign bus.dm_we    = pop;
    assign bus.dm_addr  = AW'(entries[head].addr);
    assign bus.dm_data  = entries[head].data;
    assign bus.dm_be    = entries[head].be;

    // Pointer and occupancy update; power-of-two depth makes wrap implicit.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head fields read back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push) begin
            entries[tail] <= '{addr: SB_ADDR_MAX'(bus.st_addr),
                               data: bus.st_data,
                               be:   bus.st_be};
        end
    end

    sb_fwd_merge #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fwd_merge (
        .entries   (entries),
        .head      (head),
        .count     (count),
        .ld_addr   (bus.ld_addr),
        .data      (fwd_data),
        .covered   (fwd_cov),
        .any_match (fwd_any)
    );

    assign bus.ld_hit      = bus.ld_valid && fwd_any && (fwd_cov == BE_WORD);
    assign bus.ld_conflict = bus.ld_valid && fwd_any && (fwd_cov != BE_WORD);
    assign bus.ld_data     = (bus.ld_valid && fwd_any) ? fwd_data : 32'h0;

endmodule : mips_store_buffer
`default_nettype wire

// File: tb/tb_mips_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_store_buffer
// Purpose  : Directed and random stimulus for mips_store_buffer against a
//            queue-based reference of the posted-write buffer.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_store_buffer;
    import mips_store_buffer_pkg::*;

    localparam int TB_AW = 10;

    logic clk;
    logic rst;

    mips_store_buffer_if #(.AW(TB_AW)) sb_if ();

    mips_store_buffer #(
        .DEPTH (SB_DEPTH),
        .AW    (TB_AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [TB_AW-1:0] a;
        logic [31:0]      d;
        logic [3:0]       b;
    } ref_t;

    ref_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Newest-wins lookup over the queue contents.
    task automatic lookup(input logic [TB_AW-1:0] la, output logic [31:0] md,
                          output logic [3:0] cov, output logic any);
        md = '0; cov = '0; any = 1'b0;
        foreach (q[i]) begin
            if (q[i].a == la) begin
                any = 1'b1;
                cov = cov | q[i].b;
                for (int b = 0; b < 4; b++)
                    if (q[i].b[b]) md[8*b +: 8] = q[i].d[8*b +: 8];
            end
        end
    endtask

    // One clock: drive, check combinational outputs, advance model at edge.
    task automatic step(input logic sv, input logic [TB_AW-1:0] sa,
                        input logic [31:0] sd, input logic [3:0] sbe,
                        input logic lv, input logic [TB_AW-1:0] la,
                        input logic busy);
        logic        exp_we, exp_rdy, any;
        logic [31:0] md;
        logic [3:0]  cov;
        sb_if.st_valid = sv;  sb_if.st_addr = sa;
        sb_if.st_data  = sd;  sb_if.st_be   = sbe;
        sb_if.ld_valid = lv;  sb_if.ld_addr = la;
        sb_if.dm_busy  = busy;
        #1;
        exp_we  = (q.size() != 0) && !busy;
        exp_rdy = (q.size() < SB_DEPTH) || exp_we;
        check("st_ready", sb_if.st_ready, exp_rdy);
        check("empty",    sb_if.empty,    q.size() == 0);
        check("dm_we",    sb_if.dm_we,    exp_we);
        if (exp_we) begin
            check("dm_addr", sb_if.dm_addr, q[0].a);
            check("dm_data", sb_if.dm_data, q[0].d);
            check("dm_be",   sb_if.dm_be,   q[0].b);
        end
        lookup(la, md, cov, any);
        if (lv) begin
            check("ld_hit",      sb_if.ld_hit,      any && (cov == BE_WORD));
            check("ld_conflict", sb_if.ld_conflict, any && (cov != BE_WORD));
            if (!any || cov == BE_WORD) check("ld_data", sb_if.ld_data, md);
        end else begin
            check("ld_hit_idle",      sb_if.ld_hit,      1'b0);
            check("ld_conflict_idle", sb_if.ld_conflict, 1'b0);
        end
        @(posedge clk);
        if (exp_we) void'(q.pop_front());
        if (sv && exp_rdy) q.push_back('{a: sa, d: sd, b: sbe});
        #1;
    endtask

    task automatic idle(input logic busy);
        step(1'b0, '0, '0, '0, 1'b0, '0, busy);
    endtask

    task automatic load(input logic [TB_AW-1:0] la, input logic busy);
        step(1'b0, '0, '0, '0, 1'b1, la, busy);
    endtask

    // Single-cycle reset; checks that nothing drains during it.
    task automatic do_reset(input logic busy);
        rst = 1'b1;
        sb_if.st_valid = 1'b0; sb_if.ld_valid = 1'b1; sb_if.ld_addr = '0;
        sb_if.dm_busy  = busy;
        #1;
        check("rst_dm_we", sb_if.dm_we, 1'b0);
        @(posedge clk);
        q.delete();
        #1;
        rst = 1'b0;
        #1;
        check("rst_st_ready",    sb_if.st_ready,    1'b1);
        check("rst_empty",       sb_if.empty,       1'b1);
        check("rst_dm_we_after", sb_if.dm_we,       1'b0);
        check("rst_dm_addr",     sb_if.dm_addr,     '0);
        check("rst_dm_data",     sb_if.dm_data,     '0);
        check("rst_dm_be",       sb_if.dm_be,       '0);
        check("rst_ld_hit",      sb_if.ld_hit,      1'b0);
        check("rst_ld_conflict", sb_if.ld_conflict, 1'b0);
        check("rst_ld_data",     sb_if.ld_data,     '0);
    endtask

    function automatic logic [3:0] pick_be(input int unsigned n);
        case (n % 7)
            0:       return BE_BYTE0;
            1:       return BE_BYTE1;
            2:       return BE_BYTE2;
            3:       return BE_BYTE3;
            4:       return BE_HALF_LO;
            5:       return BE_HALF_HI;
            default: return BE_WORD;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        sb_if.st_valid = 1'b0; sb_if.st_addr = '0; sb_if.st_data = '0;
        sb_if.st_be = '0; sb_if.ld_valid = 1'b0; sb_if.ld_addr = '0;
        sb_if.dm_busy = 1'b0;
        do_reset(1'b0);

        // Pass-through latency of one, then empty.
        step(1'b1, 10'h010, 32'hDEADBEEF, BE_WORD, 1'b0, '0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // Fill while memory is busy; fifth store is held off; ordered drain.
        for (int i = 1; i <= 5; i++)
            step(1'b1, TB_AW'(i), 32'h1111_0000 + 32'(i), BE_WORD, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // Full buffer with a same-cycle push and pop.
        for (int i = 1; i <= 4; i++)
            step(1'b1, TB_AW'(8 + i), 32'h2222_0000 + 32'(i), BE_WORD, 1'b0, '0, 1'b1);
        step(1'b1, 10'h00D, 32'h2222_0005, BE_WORD, 1'b0, '0, 1'b0);
        step(1'b1, 10'h00E, 32'h2222_0006, BE_WORD, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // Partial coverage conflict, then a covering word store.
        step(1'b1, 10'h020, 32'h0000_0011, BE_BYTE0, 1'b0, '0, 1'b1);
        step(1'b1, 10'h020, 32'h0000_2200, BE_BYTE1, 1'b0, '0, 1'b1);
        load(10'h020, 1'b1);
        step(1'b1, 10'h020, 32'hAABBCCDD, BE_WORD, 1'b0, '0, 1'b1);
        load(10'h020, 1'b1);
        load(10'h021, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b0);

        // Newest word wins.
        step(1'b1, 10'h030, 32'h0000_0001, BE_WORD, 1'b0, '0, 1'b1);
        step(1'b1, 10'h030, 32'h0000_0002, BE_WORD, 1'b0, '0, 1'b1);
        load(10'h030, 1'b1);
        step(1'b1, 10'h030, 32'h0000_FF00, BE_HALF_HI, 1'b0, '0, 1'b1);
        load(10'h030, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b0);

        // Reset with three entries pending discards them.
        for (int i = 0; i < 3; i++)
            step(1'b1, TB_AW'(16'h40 + i), 32'h3333_0000 + 32'(i), BE_WORD, 1'b0, '0, 1'b1);
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Random traffic over a small address window to force collisions.
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)),
                 TB_AW'(10'h050 + $urandom_range(0, 3)),
                 32'($urandom),
                 pick_be($urandom),
                 1'($urandom_range(0, 1)),
                 TB_AW'(10'h050 + $urandom_range(0, 3)),
                 1'($urandom_range(0, 99) < 55));
        end
        for (int i = 0; i < 6; i++) idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mips_store_buffer
`default_nettype wire
